// File: rtl/axi_lite_req_arbiter.sv
// axi_lite_req_arbiter
//   Shares one AXI4-Lite master request port between instruction fetch
//   (read-only) and data load/store. One transaction runs at a time. The
//   winner's request is latched and issued as a single-cycle m_req pulse. The
//   master's completion is then routed back to the granted requester in the
//   same cycle.
//
// Parameters
//   DATA_PRIORITY : 0 = round-robin on a tie, 1 = data always wins a tie
//   RESET_GRANT   : round-robin pointer after reset (0 = fetch, 1 = data)
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   if_req/if_addr              fetch request (held until if_ready)
//   if_rdata/if_ready/if_error  fetch completion
//   d_req/d_wr/d_addr/d_wdata/d_wstrb  data request (held until d_ready)
//   d_rdata/d_ready/d_error     data completion
//   m_req/m_wr/m_addr/m_wdata/m_wstrb  request to master (m_req 1-cycle pulse)
//   m_rdata/m_ready/m_error     master completion
//   busy                        transaction in flight
//   grant_d                     current/last grant (1 = data, 0 = fetch)
module axi_lite_req_arbiter #(
  parameter bit DATA_PRIORITY = 1'b0,
  parameter bit RESET_GRANT   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_error,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_error,
  output logic        m_req,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  input  logic        m_error,
  output logic        busy,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   rr_d;      // 1 = data favoured on the next tie
  logic   pick_d;    // data wins if granted this cycle
  logic   done;      // completion accepted this cycle

  always_comb begin
    pick_d    = d_req & (~if_req | DATA_PRIORITY | rr_d);
    done      = (state == WAIT) & m_ready;
    state_nxt = state;
    case (state)
      IDLE:    if (if_req | d_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      grant_d <= 1'b0;
      rr_d    <= RESET_GRANT;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (if_req | d_req)) begin
        grant_d <= pick_d;
        if (pick_d) begin
          m_wr    <= d_wr;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          m_wstrb <= d_wstrb;
        end else begin
          // Fetch is read-only: write-side fields are forced quiet.
          m_wr    <= 1'b0;
          m_addr  <= if_addr;
          m_wdata <= '0;
          m_wstrb <= '0;
        end
      end
      // Favour the side that was not just served.
      if (done) rr_d <= ~grant_d;
    end
  end

  assign m_req    = (state == ISSUE);
  assign busy     = (state != IDLE);

  // Completion is combinational so the requester sees ready with m_ready.
  assign if_ready = done & ~grant_d;
  assign d_ready  = done &  grant_d;
  assign if_error = done & ~grant_d & m_error;
  assign d_error  = done &  grant_d & m_error;
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
module tb_axi_lite_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, d_req, d_wr;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready, m_error;

  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ready, if_error, d_ready, d_error, m_req, m_wr, busy, grant_d;
  logic [3:0]  m_wstrb;

  logic        f_if_req, f_d_req, f_m_ready;
  logic [31:0] f_if_rdata, f_d_rdata, f_m_addr, f_m_wdata;
  logic        f_if_ready, f_if_error, f_d_ready, f_d_error, f_m_req, f_m_wr, f_busy, f_grant_d;
  logic [3:0]  f_m_wstrb;

  axi_lite_req_arbiter #(.DATA_PRIORITY(1'b0), .RESET_GRANT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_error(if_error),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_error(d_error),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
    .busy(busy), .grant_d(grant_d)
  );

  axi_lite_req_arbiter #(.DATA_PRIORITY(1'b1), .RESET_GRANT(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .if_req(f_if_req), .if_addr(if_addr), .if_rdata(f_if_rdata), .if_ready(f_if_ready), .if_error(f_if_error),
    .d_req(f_d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(f_d_rdata), .d_ready(f_d_ready), .d_error(f_d_error),
    .m_req(f_m_req), .m_wr(f_m_wr), .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb),
    .m_rdata(m_rdata), .m_ready(f_m_ready), .m_error(m_error),
    .busy(f_busy), .grant_d(f_grant_d)
  );

  typedef struct {
    bit          if_v;
    bit          d_v;
    bit          d_wr;
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] rdata;
    bit          err;
    int unsigned lat;
    bit          exp_gd;
  } vec_t;

  typedef struct {
    bit          gd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  vec_t vt[14];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   seen;
  bit   exp_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic apply(input vec_t v);
    exp_t e;
    bit   found;
    if_req  = v.if_v;
    d_req   = v.d_v;
    if_addr = v.if_addr;
    d_wr    = v.d_wr;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    d_wstrb = v.d_wstrb;
    e.gd    = v.exp_gd;
    e.wr    = v.exp_gd ? v.d_wr : 1'b0;
    e.addr  = v.exp_gd ? v.d_addr : v.if_addr;
    e.wdata = v.exp_gd ? v.d_wdata : 32'h0;
    e.wstrb = v.exp_gd ? v.d_wstrb : 4'h0;
    e.rdata = v.rdata;
    e.err   = v.err;
    sb.push_back(e);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_req) found = 1'b1;
      else if (i == 0) chk("idle_busy", busy, 0);
    end
    if (!found) begin
      chk("mreq_timeout", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("issue_m_wr", m_wr, e.wr);
    chk("issue_m_addr", m_addr, e.addr);
    chk("issue_m_wdata", m_wdata, e.wdata);
    chk("issue_m_wstrb", m_wstrb, e.wstrb);
    chk("issue_grant_d", grant_d, e.gd);
    chk("issue_busy", busy, 1);
    for (int unsigned k = 0; k < v.lat; k++) begin
      @(negedge clk);
      chk("wait_m_req", m_req, 0);
      chk("wait_busy", busy, 1);
      chk("wait_m_addr", m_addr, e.addr);
      chk("wait_m_wdata", m_wdata, e.wdata);
      chk("wait_m_wstrb", m_wstrb, e.wstrb);
      chk("wait_no_ready", {if_ready, d_ready}, 0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    m_rdata = v.rdata;
    m_error = v.err;
    @(negedge clk);
    chk("if_ready", if_ready, !e.gd);
    chk("d_ready", d_ready, e.gd);
    chk("if_error", if_error, !e.gd && e.err);
    chk("d_error", d_error, e.gd && e.err);
    chk("rdata", e.gd ? d_rdata : if_rdata, e.rdata);
    @(posedge clk); #1;
    m_ready = 1'b0;
    m_error = 1'b0;
    if (e.gd) d_req = 1'b0;
    else if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          if d  wr  if_addr        d_addr         d_wdata        wstrb    rdata          err lat gd
    vt[0]  = '{1, 0, 0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 4'h0,    32'h0000_0013, 0, 3, 0};
    vt[1]  = '{0, 1, 1, 32'h0000_0100, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011, 32'h0000_0055, 0, 2, 1};
    vt[2]  = '{1, 1, 1, 32'h0000_0200, 32'h1000_0010, 32'hCAFE_F00D, 4'hF,    32'h0000_1111, 0, 1, 0};
    vt[3]  = '{1, 1, 1, 32'h0000_0204, 32'h1000_0010, 32'hCAFE_F00D, 4'hF,    32'h0000_2222, 0, 1, 1};
    vt[4]  = '{1, 1, 0, 32'h0000_0204, 32'h1000_0014, 32'h0000_0000, 4'h0,    32'h0000_3333, 0, 2, 0};
    vt[5]  = '{1, 1, 0, 32'h0000_0208, 32'h1000_0014, 32'h0000_0000, 4'h0,    32'h0000_4444, 0, 0, 1};
    vt[6]  = '{0, 1, 0, 32'h0000_0208, 32'hF000_0000, 32'h0000_0000, 4'h0,    32'h0000_0BAD, 1, 1, 1};
    vt[7]  = '{1, 0, 0, 32'h0000_0300, 32'hF000_0000, 32'h0000_0000, 4'h0,    32'h0000_0077, 0, 0, 0};
    vt[8]  = '{1, 1, 1, 32'h0000_0304, 32'h2000_0000, 32'hA5A5_A5A5, 4'b1100, 32'h0000_5555, 0, 1, 1};
    vt[9]  = '{1, 1, 0, 32'h0000_0304, 32'h2000_0004, 32'h1234_5678, 4'h0,    32'h0000_6666, 0, 1, 0};
    vt[10] = '{0, 1, 0, 32'h0000_0304, 32'h2000_0004, 32'h1234_5678, 4'h0,    32'h0000_7777, 0, 2, 1};
    vt[11] = '{1, 0, 0, 32'h0000_03FC, 32'h2000_0004, 32'h0000_0000, 4'h0,    32'h0000_0099, 0, 1, 0};
    vt[12] = '{1, 1, 1, 32'h0000_0500, 32'h3000_0000, 32'h0F0F_0F0F, 4'b0001, 32'h0000_8888, 0, 1, 0};
    vt[13] = '{0, 1, 1, 32'h0000_0500, 32'h3000_0000, 32'h0F0F_0F0F, 4'b0001, 32'h0000_9999, 0, 1, 1};

    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    m_rdata = '0; m_ready = 1'b1; m_error = 1'b1;
    f_if_req = 1'b0; f_d_req = 1'b0; f_m_ready = 1'b0;

    // Reset state, with a completion asserted that must be ignored.
    repeat (2) @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_grant_d", grant_d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {if_ready, d_ready, if_error, d_error}, 0);
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b0; m_error = 1'b0;
    @(posedge clk); #1;

    // Fixed-priority instance: data wins every tie, fetch only once d_req drops.
    if_addr = 32'h0000_0600; d_addr = 32'h7000_0000; d_wr = 1'b1;
    d_wdata = 32'h0BAD_CAFE; d_wstrb = 4'b0110;
    f_if_req = 1'b1; f_d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = f_m_req;
      end
      if (!seen) begin
        chk("fp_mreq_timeout", 0, 1);
        break;
      end
      exp_d = (t < 3);
      chk("fp_grant", f_grant_d, exp_d);
      chk("fp_addr", f_m_addr, exp_d ? d_addr : if_addr);
      chk("fp_wr", f_m_wr, exp_d ? d_wr : 1'b0);
      chk("fp_wdata", f_m_wdata, exp_d ? d_wdata : 32'h0);
      chk("fp_wstrb", f_m_wstrb, exp_d ? d_wstrb : 4'h0);
      chk("fp_busy", f_busy, 1);
      @(posedge clk); #1;
      f_m_ready = 1'b1;
      m_rdata = 32'hF00D_0000 + t;
      @(negedge clk);
      chk("fp_d_ready", f_d_ready, exp_d);
      chk("fp_if_ready", f_if_ready, !exp_d);
      chk("fp_error", {f_if_error, f_d_error}, 0);
      chk("fp_rdata", exp_d ? f_d_rdata : f_if_rdata, 32'hF00D_0000 + t);
      @(posedge clk); #1;
      f_m_ready = 1'b0;
      if (t == 2) f_d_req = 1'b0;
      if (t == 3) f_if_req = 1'b0;
    end
    chk("main_idle_during_fp", busy, 0);

    // Round-robin instance vectors.
    for (int unsigned n = 0; n < 12; n++) apply(vt[n]);

    // Reset in the middle of WAIT: no completion may escape.
    if_req = 1'b1; if_addr = 32'h0000_0400;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = m_req;
    end
    if (!seen) chk("rstw_mreq_timeout", 0, 1);
    @(negedge clk);
    chk("rstw_busy_before", busy, 1);
    #1;
    rst = 1'b1; m_ready = 1'b1; m_error = 1'b1;
    #1;
    chk("rstw_m_req", m_req, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_m_addr", m_addr, 0);
    chk("rstw_no_ready", {if_ready, d_ready, if_error, d_error}, 0);
    @(posedge clk); #1;
    if_req = 1'b0; m_ready = 1'b0; m_error = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // Stray completion while idle.
    m_ready = 1'b1; m_error = 1'b1;
    @(negedge clk);
    chk("stray_no_ready", {if_ready, d_ready, if_error, d_error}, 0);
    chk("stray_busy", busy, 0);
    @(posedge clk); #1;
    m_ready = 1'b0; m_error = 1'b0;

    // Pointer back at RESET_GRANT: fetch wins the first tie.
    apply(vt[12]);
    apply(vt[13]);

    repeat (2) @(negedge clk);
    chk("final_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
